masked_cumdiff_module_094: RTL and testbench

MASKED_CUMDIFF_MODULE_094 -- requirements
Module: masked_cumdiff_module_094

---
 rtl/masked_cumdiff_module_094.sv | 100 ++++++++++
 tb/tb_masked_cumdiff_module_094.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/masked_cumdiff_module_094.sv
// rtl/masked_cumdiff_module_094.sv - recovers masked elements from a per-row cumulative sum
// Row-segmented adjacent difference with mask consistency check and a single output register.
module masked_cumdiff_module_094 #(
  parameter int DATA_W  = 32,
  parameter int ROW_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] input_data,
  input  logic              mask_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out,
  output logic              err_out,
  output logic              err_sticky
);

  typedef enum logic {ROW_START, IN_ROW} row_state_t;

  localparam logic [15:0] LAST_COL = 16'(ROW_LEN - 1);

  row_state_t        state, state_nxt;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] diff;
  logic [15:0]       col;
  logic              accept;
  logic              at_last;
  logic              elem_err;

  // Output register frees up in the same cycle it is drained, giving full throughput.
  assign ready_in = !valid_out || ready_out;
  assign accept   = valid_in && ready_in;

  always_ff @(posedge clk) begin
    if (rst) state <= ROW_START;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        ROW_START: state_nxt = IN_ROW;
        IN_ROW:    if (at_last) state_nxt = ROW_START;
        default:   state_nxt = ROW_START;
      endcase
    end
  end

  // A fresh row differences against zero regardless of what prev holds.
  always_comb begin
    base    = '0;
    at_last = 1'b0;
    if (state == IN_ROW) begin
      base    = prev;
      at_last = (col == LAST_COL);
    end
  end

  assign diff     = input_data - base;
  assign elem_err = !mask_in && (diff != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      col  <= '0;
    end else if (accept) begin
      if (at_last) begin
        prev <= '0;
        col  <= '0;
      end else begin
        prev <= input_data;
        col  <= col + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      output_data <= '0;
      last_out    <= 1'b0;
      err_out     <= 1'b0;
      err_sticky  <= 1'b0;
    end else if (accept) begin
      valid_out   <= 1'b1;
      output_data <= mask_in ? diff : '0;
      last_out    <= at_last;
      err_out     <= elem_err;
      err_sticky  <= err_sticky | elem_err;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_masked_cumdiff_module_094.sv
// tb/tb_masked_cumdiff_module_094.sv - scoreboard bench for masked_cumdiff_module_094
// Driver pushes expected responses on accept; a monitor pops them on every output transfer.
module tb_masked_cumdiff_module_094;

  localparam int DW = 32;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] input_data;
  logic          mask_in;
  logic          valid_out;
  logic          ready_out;
  logic [DW-1:0] output_data;
  logic          last_out;
  logic          err_out;
  logic          err_sticky;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ro_mode = 0;  // 0: ready_out=1, 1: random, 2: ready_out=0

  logic [DW-1:0] m_prev;
  int            m_col;

  masked_cumdiff_module_094 #(.DATA_W(DW), .ROW_LEN(RL)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .input_data(input_data), .mask_in(mask_in), .valid_out(valid_out),
    .ready_out(ready_out), .output_data(output_data), .last_out(last_out),
    .err_out(err_out), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ro_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = 1'($urandom_range(0, 1));
      default: ready_out = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", output_data, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("output_data", output_data, e.data);
        chk("last_out", {31'd0, last_out}, {31'd0, e.last});
        chk("err_out", {31'd0, err_out}, {31'd0, e.err});
      end
    end
  end

  task automatic send(input logic [DW-1:0] y, input logic m,
                      input logic [DW-1:0] ed, input logic el, input logic ee);
    int n;
    valid_in   = 1'b1;
    input_data = y;
    mask_in    = m;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    exp_q.push_back('{data: ed, last: el, err: ee});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Reference adjacent-difference model for the randomized stream.
  task automatic send_model(input logic [DW-1:0] y, input logic m);
    logic [DW-1:0] d;
    d = y - ((m_col == 0) ? '0 : m_prev);
    m_prev = y;
    send(y, m, m ? d : '0, m_col == RL - 1, !m && d != '0);
    m_col = (m_col == RL - 1) ? 0 : m_col + 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; input_data = '0; mask_in = 1'b0; ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_output_data", output_data, 32'd0);
    chk("rst_last_out", {31'd0, last_out}, 32'd0);
    chk("rst_err_out", {31'd0, err_out}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_ready_in", {31'd0, ready_in}, 32'd1);
    @(posedge clk); #1;

    send(3, 1, 3, 0, 0); send(5, 1, 2, 0, 0); send(5, 1, 0, 0, 0); send(12, 1, 7, 1, 0);
    send(4, 1, 4, 0, 0); send(4, 0, 0, 0, 0); send(10, 1, 6, 0, 0); send(10, 0, 0, 1, 0);
    send(1, 1, 1, 0, 0); send(1, 1, 0, 0, 0); send(1, 1, 0, 0, 0); send(1, 1, 0, 1, 0);
    drain();
    chk("sticky_clean", {31'd0, err_sticky}, 32'd0);

    send(2, 1, 2, 0, 0); send(9, 0, 0, 0, 1); send(9, 1, 0, 0, 0); send(9, 1, 0, 1, 0);
    drain();
    chk("sticky_set", {31'd0, err_sticky}, 32'd1);

    send(32'h7FFFFFFF, 1, 32'h7FFFFFFF, 0, 0); send(32'h80000000, 1, 32'h00000001, 0, 0);
    send(32'h80000000, 1, 0, 0, 0); send(32'h00000000, 1, 32'h80000000, 1, 0);
    drain();
    chk("sticky_held", {31'd0, err_sticky}, 32'd1);

    // Backpressure: one element parked in the output register, next one stalled.
    ro_mode = 2;
    @(posedge clk); #1;
    send(10, 1, 10, 0, 0);
    valid_in = 1'b1; input_data = 15; mask_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready_in", {31'd0, ready_in}, 32'd0);
      chk("stall_valid_out", {31'd0, valid_out}, 32'd1);
      chk("stall_data", output_data, 32'd10);
    end
    ro_mode = 0;
    send(15, 1, 5, 0, 0); send(15, 1, 0, 0, 0); send(20, 1, 5, 1, 0);
    drain();

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {31'd0, err_sticky}, 32'd0);
    @(posedge clk); #1;

    ro_mode = 1;
    m_prev = '0; m_col = 0;
    for (int i = 0; i < 2 * RL + 2; i++)
      send_model($urandom_range(0, 1000), 1'($urandom_range(0, 3) != 0));
    drain();
    // Reset collides with an offered element at col 2; reset wins.
    valid_in = 1'b1; input_data = 77; mask_in = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid_out", {31'd0, valid_out}, 32'd0);
    @(posedge clk); #1;
    m_prev = '0; m_col = 0;
    send(40, 1, 40, 0, 0); send(45, 1, 5, 0, 0);
    m_prev = 45; m_col = 2;
    for (int i = 0; i < RL + 2; i++)
      send_model($urandom_range(0, 1000), 1'($urandom_range(0, 3) != 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
